// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the fetch stage: machine word, primary opcodes and the fetch FSM encoding.
package instr_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    HALT     = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} fetch_state_t;

  localparam word_t WBYTES = 32'd4;

  function automatic logic is_halt(input word_t w);
    return w[31:26] == HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem request/response on one side, decode handshake and redirect on the other.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iren;
  word_t iaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t instr;
  logic  instr_valid;
  word_t instr_pc;
  word_t npc;
  logic  halt;

  modport master (
    input  ihit, iload, stall, redirect, redirect_pc,
    output iren, iaddr, instr, instr_valid, instr_pc, npc, halt
  );

  modport slave (
    output ihit, iload, stall, redirect, redirect_pc,
    input  iren, iaddr, instr, instr_valid, instr_pc, npc, halt
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, requests imem words, holds one instruction for decode,
// applies decode redirects and parks itself after a consumed HALT.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic              CLK,
  input logic              RST,
  instr_fetch_unit_if.master bus
);

  fetch_state_t state;
  word_t        pc;
  word_t        instr_q;
  word_t        instr_pc_q;
  logic         valid_q;
  logic         halt_q;

  logic consume;
  logic accept;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    consume  = valid_q & ~bus.stall;
    bus.iren = (state == RUN) & ~RST & (~valid_q | consume);
    accept   = bus.iren & bus.ihit & ~bus.redirect;
  end

  assign bus.iaddr       = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.npc         = instr_pc_q + WBYTES;
  assign bus.halt        = halt_q;

  // NOTE: state is written only with non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // Redirect beats both a coincident imem hit and a decode stall.
          if (bus.redirect) begin
            pc      <= bus.redirect_pc & ~(WBYTES - 32'd1);
            valid_q <= 1'b0;
          end else if (accept) begin
            instr_q    <= bus.iload;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
            pc         <= pc + WBYTES;
            if (is_halt(bus.iload)) state <= HALT_PEND;
          end else if (consume) begin
            valid_q <= 1'b0;
          end
        end

        HALT_PEND: begin
          if (bus.redirect) begin
            pc      <= bus.redirect_pc & ~(WBYTES - 32'd1);
            valid_q <= 1'b0;
            state   <= RUN;
          end else if (consume) begin
            valid_q <= 1'b0;
            halt_q  <= 1'b1;
            state   <= HALTED;
          end
        end

        HALTED: ;

        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random traffic against a
// transaction-level model of the fetch stage.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if wbus ();

  instr_fetch_unit #(.PC_INIT(32'h0000_0040)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  instr_fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut_wrap (
    .CLK (clk),
    .RST (rst),
    .bus (wbus.master)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: what decode should see and where fetch should be pointing.
  word_t m_pc, m_instr, m_instr_pc;
  bit    m_valid, m_halt_pending, m_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t word_at(input word_t a);
    return {6'h01, a[25:0]};
  endfunction

  task automatic model_reset();
    m_pc = 32'h40; m_instr = '0; m_instr_pc = '0;
    m_valid = 0; m_halt_pending = 0; m_halted = 0;
  endtask

  // Drive one cycle of inputs, compare every output against the model, advance the model.
  task automatic tick(input bit r, input bit hit, input bit st, input bit rd,
                      input word_t rpc, input word_t word);
    bit exp_iren;
    rst = r; bus.ihit = hit; bus.stall = st; bus.redirect = rd;
    bus.redirect_pc = rpc; bus.iload = word;
    #1;
    exp_iren = !r && !m_halt_pending && !m_halted && (!m_valid || !st);
    check("iren",        {31'b0, bus.iren},        {31'b0, exp_iren});
    check("iaddr",       bus.iaddr,                m_pc);
    check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_valid});
    check("instr",       bus.instr,                m_instr);
    check("instr_pc",    bus.instr_pc,             m_instr_pc);
    check("npc",         bus.npc,                  m_instr_pc + 32'd4);
    check("halt",        {31'b0, bus.halt},        {31'b0, m_halted});
    if (r) begin
      model_reset();
    end else if (!m_halted) begin
      if (rd) begin
        m_pc = rpc & 32'hFFFF_FFFC;
        m_valid = 0;
        m_halt_pending = 0;
      end else if (exp_iren && hit) begin
        m_instr = word; m_instr_pc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1;
        if (word[31:26] == 6'h3F) m_halt_pending = 1;
      end else if (m_valid && !st) begin
        m_valid = 0;
        if (m_halt_pending) begin m_halt_pending = 0; m_halted = 1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input bit hit, input bit st);
    tick(1'b0, hit, st, 1'b0, '0, word_at(m_pc));
  endtask

  task automatic jump(input word_t target);
    tick(1'b0, 1'b0, 1'b0, 1'b1, target, '0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ihit = 0; bus.iload = '0; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    wbus.ihit = 1; wbus.iload = '0; wbus.stall = 0; wbus.redirect = 0; wbus.redirect_pc = '0;

    // Reset
    @(negedge clk); @(negedge clk);
    model_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b0, '0, word_at(32'h40));
    rst = 1'b0; #1;
    check("reset_iaddr", bus.iaddr, 32'h40);
    check("reset_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("reset_instr", bus.instr, 32'd0);

    // Back-to-back fetch from PC_INIT
    for (int i = 0; i < 3; i++) begin
      check("seq_iaddr", bus.iaddr, 32'h40 + 32'(4 * i));
      run(1'b1, 1'b0);
      if (i == 0) begin
        check("wrap_iaddr", wbus.iaddr, 32'h0);
        check("wrap_npc", wbus.npc, 32'h0);
        check("wrap_instr_pc", wbus.instr_pc, 32'hFFFF_FFFC);
      end
    end
    check("seq_instr_pc", bus.instr_pc, 32'h48);
    check("seq_npc", bus.npc, 32'h4C);

    // Slow memory: three wait cycles, then the hit
    for (int i = 0; i < 3; i++) run(1'b0, 1'b0);
    check("wait_iaddr", bus.iaddr, 32'h4C);
    run(1'b1, 1'b0);
    check("wait_instr_pc", bus.instr_pc, 32'h4C);

    // Decode stall freezes the output register and the PC
    for (int i = 0; i < 4; i++) begin
      run(1'b1, 1'b1);
      check("stall_iren", {31'b0, bus.iren}, 32'd0);
      check("stall_instr_pc", bus.instr_pc, 32'h4C);
    end
    run(1'b1, 1'b0);
    check("release_instr_pc", bus.instr_pc, 32'h50);

    // Redirect with a coincident hit: word dropped, target aligned
    jump(32'h10);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h203, word_at(32'h10));
    check("redir_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("redir_iaddr", bus.iaddr, 32'h200);

    // HALT held by stall, then consumed
    jump(32'h8);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0, 32'hFC00_0000);
    tick(1'b0, 1'b1, 1'b1, 1'b0, '0, 32'hFC00_0000);
    check("hpend_iren", {31'b0, bus.iren}, 32'd0);
    check("hpend_halt", {31'b0, bus.halt}, 32'd0);
    run(1'b1, 1'b0);
    check("halted_halt", {31'b0, bus.halt}, 32'd1);
    check("halted_iren", {31'b0, bus.iren}, 32'd0);
    jump(32'h300);
    check("halted_redir_iaddr", bus.iaddr, 32'h0C);
    check("halted_redir_halt", {31'b0, bus.halt}, 32'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check("halt_reset_iaddr", bus.iaddr, 32'h40);
    check("halt_reset_halt", {31'b0, bus.halt}, 32'd0);

    // HALT squashed by a redirect that coincides with consume
    jump(32'h8);
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'hFC00_0000);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, word_at(32'h0C));
    check("squash_halt", {31'b0, bus.halt}, 32'd0);
    check("squash_iaddr", bus.iaddr, 32'h100);
    check("squash_valid", {31'b0, bus.instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0);
    check("squash_run_iaddr", bus.iaddr, 32'h10C);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      word_t w;
      w = $urandom;
      if ($urandom_range(0, 19) == 0) w[31:26] = 6'h3F;
      tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, $urandom, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
